branch_target_buffer: RTL and testbench
=======================================

# branch_target_buffer

Direct-mapped branch target buffer with 2-bit saturating direction counters, located in the IF stage directly upstream of the IF/ID pipeline register. Every cycle it looks up the fetch PC and produces the predicted next PC and a tag-match flag; both are latched into IF/ID alongside the fetched instruction. Branches and jumps resolved in EX write their outcome back into the buffer, so later fetches of the same PC predict better.

## Interface
Parameters:
- WORD_SIZE, 16, PC/data width (word-addressed PC)
- INDEX_BITS, 8, log2 of entry count (256 entries); legal range 1..WORD_SIZE-1

Ports:
- clk  in  1  clock, all state updates on posedge
- reset_n  in  1  synchronous, active-low reset
- pc_IF  in  WORD_SIZE  current fetch PC
- branch_predicted_pc_IF  out  WORD_SIZE  predicted next fetch PC, to PC register and IF/ID
- tag_match_IF  out  1  lookup hit (valid entry, tag equal), to IF/ID
- update_en  in  1  EX resolved a control-transfer instruction this cycle (caller gates off stalls and flushed bubbles)
- update_pc  in  WORD_SIZE  PC of the resolved instruction
- update_taken  in  1  actual outcome; jumps always drive 1
- update_target  in  WORD_SIZE  actual target when taken

## Operation
- Field split: index = pc[INDEX_BITS-1:0]; tag = pc[WORD_SIZE-1:INDEX_BITS] (TAG_BITS = WORD_SIZE-INDEX_BITS).
- Entry state: valid (1), tag (TAG_BITS), target (WORD_SIZE), ctr (2). All in flops.
- Lookup (combinational on pc_IF and current state):
  - tag_match_IF = valid[idx] & (tag[idx] == pc_IF tag).
  - branch_predicted_pc_IF = (tag_match_IF & ctr[idx][1]) ? target[idx] : pc_IF + 1.
  - pc_IF + 1 is truncated to WORD_SIZE: 0xFFFF -> 0x0000.
- Update (posedge, when reset_n=1 and update_en=1), applied to entry u = update_pc index:
  - Hit (valid & tag equal): ctr <- sat_inc(ctr) if taken, else sat_dec(ctr). Saturates at 2'b11 and 2'b00. If taken, target <- update_target; otherwise target is unchanged.
  - Miss, taken: allocate or replace the entry. valid <- 1, tag <- update_pc tag, target <- update_target, ctr <- 2'b10 (weakly taken).
  - Miss, not taken: no state change. No allocation.
- Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T; predict taken iff ctr[1].
- Only one update per cycle; other entries are untouched.

## Timing
- Lookup latency: 0 cycles. Outputs are purely combinational from pc_IF and registered state. No output registers; IF/ID does the latching.
- Update latency: 1 cycle. State written at posedge N is visible to lookups from cycle N+1 onward.
- Same-cycle lookup and update to the same index: the lookup uses the pre-update state. No bypass.
- Reset (reset_n=0 at posedge): every valid <- 0, every ctr <- 2'b01, every tag <- 0, every target <- 0, completed in that single cycle.
  - Reset overrides any concurrent update_en.
  - Post-reset outputs: tag_match_IF = 0, branch_predicted_pc_IF = pc_IF + 1.
- A reset asserted mid-sequence discards all learned history. No partial-entry state is possible because each update is atomic in one edge.
- Aliasing: two PCs with equal index but different tag evict each other on taken updates. A not-taken miss never evicts.

## Test plan
- Reset: hold reset_n=0 for 1 cycle, release, drive pc_IF=0x0040 -> tag_match_IF=0, branch_predicted_pc_IF=0x0041; pc_IF=0xFFFF -> predicted 0x0000.
- Allocate: update_en=1, update_pc=0x0123, taken=1, target=0x0200 at edge N.
  - pc_IF=0x0123 in cycle N -> tag_match_IF=0, predicted 0x0124.
  - pc_IF=0x0123 in cycle N+1 -> tag_match_IF=1, predicted 0x0200.
- Counter saturation on entry 0x0123: three not-taken updates.
  - After the first: ctr=01, prediction falls back to 0x0124 with tag_match_IF=1.
  - After the third: ctr=00.
  - Four taken updates with target 0x0300 -> ctr=11, predicted 0x0300.
  - One further not-taken -> ctr=10, still predicts 0x0300.
- Not-taken miss: update pc=0x0555, taken=0 -> lookup 0x0555 gives tag_match_IF=0, predicted 0x0556. No entry allocated.
- Aliasing: allocate 0x0123 -> 0x0200, then taken update pc=0x1123 target 0x0400.
  - Lookup 0x0123 -> tag_match_IF=0, predicted 0x0124.
  - Lookup 0x1123 -> tag_match_IF=1, predicted 0x0400.
- Reset during update: reset_n=0 and update_en=1 (pc 0x0010, taken, target 0x0020) on the same edge -> lookup 0x0010 afterwards gives tag_match_IF=0, predicted 0x0011.

Source files
------------

// File: rtl/branch_target_buffer_if.sv
// Fetch-side lookup and EX-side resolution signals of the branch target buffer.
// The pipeline drives through master; the buffer itself sits on slave.
interface branch_target_buffer_if #(
   parameter int WORD_SIZE = 16
);
   logic [WORD_SIZE-1:0] pc_IF;
   logic [WORD_SIZE-1:0] branch_predicted_pc_IF;
   logic                 tag_match_IF;
   logic                 update_en;
   logic [WORD_SIZE-1:0] update_pc;
   logic                 update_taken;
   logic [WORD_SIZE-1:0] update_target;

   modport master (
      output pc_IF,
      output update_en,
      output update_pc,
      output update_taken,
      output update_target,
      input  branch_predicted_pc_IF,
      input  tag_match_IF
   );

   modport slave (
      input  pc_IF,
      input  update_en,
      input  update_pc,
      input  update_taken,
      input  update_target,
      output branch_predicted_pc_IF,
      output tag_match_IF
   );
endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with 2-bit saturating direction counters.
// Lookup is combinational on the fetch PC; EX outcomes are written back on the clock edge.
module branch_target_buffer #(
   parameter int WORD_SIZE  = 16,
   parameter int INDEX_BITS = 8
) (
   input logic clk,
   input logic reset_n,
   branch_target_buffer_if.slave bus
);
   localparam int TAG_BITS = WORD_SIZE - INDEX_BITS;
   localparam int ENTRIES  = 1 << INDEX_BITS;
   localparam logic [WORD_SIZE-1:0] ONE = {{(WORD_SIZE-1){1'b0}}, 1'b1};

   logic                 valid_q  [ENTRIES];
   logic [TAG_BITS-1:0]  tag_q    [ENTRIES];
   logic [WORD_SIZE-1:0] target_q [ENTRIES];
   logic [1:0]           ctr_q    [ENTRIES];

   logic [INDEX_BITS-1:0] lk_idx;
   logic [TAG_BITS-1:0]   lk_tag;
   logic                  lk_hit;

   assign lk_idx = bus.pc_IF[INDEX_BITS-1:0];
   assign lk_tag = bus.pc_IF[WORD_SIZE-1:INDEX_BITS];
   assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

   assign bus.tag_match_IF = lk_hit;
   assign bus.branch_predicted_pc_IF =
      (lk_hit && ctr_q[lk_idx][1]) ? target_q[lk_idx] : bus.pc_IF + ONE;

   logic [INDEX_BITS-1:0] up_idx;
   logic [TAG_BITS-1:0]   up_tag;
   logic                  up_hit;
   logic [1:0]            ctr_cur;
   logic [1:0]            ctr_next;

   assign up_idx = bus.update_pc[INDEX_BITS-1:0];
   assign up_tag = bus.update_pc[WORD_SIZE-1:INDEX_BITS];
   assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

   always_comb begin
      ctr_cur  = ctr_q[up_idx];
      ctr_next = ctr_cur;
      if (bus.update_taken) begin
         if (ctr_cur != 2'b11) ctr_next = ctr_cur + 2'b01;
      end else begin
         if (ctr_cur != 2'b00) ctr_next = ctr_cur - 2'b01;
      end
   end

   // A not-taken miss leaves the table alone so it never evicts a useful entry.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            ctr_q[i]    <= 2'b01;
         end
      end else if (bus.update_en) begin
         if (up_hit) begin
            ctr_q[up_idx] <= ctr_next;
            if (bus.update_taken) target_q[up_idx] <= bus.update_target;
         end else if (bus.update_taken) begin
            valid_q[up_idx]  <= 1'b1;
            tag_q[up_idx]    <= up_tag;
            target_q[up_idx] <= bus.update_target;
            ctr_q[up_idx]    <= 2'b10;
         end
      end
   end
endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed bench for branch_target_buffer: stimulus queues expected lookups,
// a negedge monitor pops and compares them.
module tb_branch_target_buffer;
   logic clk;
   logic reset_n;

   branch_target_buffer_if #(.WORD_SIZE(16)) bus ();

   branch_target_buffer #(
      .WORD_SIZE (16),
      .INDEX_BITS(8)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] pc;
      logic        hit;
      logic [15:0] pred;
   } exp_t;

   exp_t exp_q[$];
   logic chk;
   int   n_vec;
   int   n_bad;

   always @(negedge clk) begin
      if (chk) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard_empty: lookup strobe with no expected entry");
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (bus.tag_match_IF !== e.hit ||
                bus.branch_predicted_pc_IF !== e.pred) begin
               n_bad++;
               $display("FAIL lookup pc=%h: got hit=%b pred=%h, want hit=%b pred=%h",
                        e.pc, bus.tag_match_IF, bus.branch_predicted_pc_IF,
                        e.hit, e.pred);
            end
         end
      end
   end

   // One clock cycle: optional update and optional lookup in the same cycle.
   task automatic cyc(input logic en, input logic [15:0] upc,
                      input logic tk, input logic [15:0] tg,
                      input logic lk, input logic [15:0] lpc,
                      input logic eh, input logic [15:0] ep);
      exp_t e;
      bus.update_en     = en;
      bus.update_pc     = upc;
      bus.update_taken  = tk;
      bus.update_target = tg;
      bus.pc_IF         = lpc;
      if (lk) begin
         e.pc = lpc; e.hit = eh; e.pred = ep;
         exp_q.push_back(e);
         chk = 1'b1;
      end
      @(posedge clk);
      #1;
      chk           = 1'b0;
      bus.update_en = 1'b0;
   endtask

   task automatic upd(input logic [15:0] upc, input logic tk,
                      input logic [15:0] tg);
      cyc(1'b1, upc, tk, tg, 1'b0, 16'h0000, 1'b0, 16'h0000);
   endtask

   task automatic look(input logic [15:0] lpc, input logic eh,
                       input logic [15:0] ep);
      cyc(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, lpc, eh, ep);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_vec = 0;
      n_bad = 0;
      chk = 1'b0;
      reset_n = 1'b0;
      bus.pc_IF = 16'h0000;
      bus.update_en = 1'b0;
      bus.update_pc = 16'h0000;
      bus.update_taken = 1'b0;
      bus.update_target = 16'h0000;
      @(posedge clk);
      #1;
      upd(16'h0000, 1'b0, 16'h0000);
      reset_n = 1'b1;

      look(16'h0040, 1'b0, 16'h0041);
      look(16'hFFFF, 1'b0, 16'h0000);

      // allocate, with same-cycle lookup seeing pre-update state
      cyc(1'b1, 16'h0123, 1'b1, 16'h0200, 1'b1, 16'h0123, 1'b0, 16'h0124);
      look(16'h0123, 1'b1, 16'h0200);

      // down to strongly not-taken, saturating at 00
      upd(16'h0123, 1'b0, 16'h0000);
      look(16'h0123, 1'b1, 16'h0124);
      upd(16'h0123, 1'b0, 16'h0000);
      upd(16'h0123, 1'b0, 16'h0000);
      look(16'h0123, 1'b1, 16'h0124);

      // back up to strongly taken, saturating at 11
      upd(16'h0123, 1'b1, 16'h0300);
      look(16'h0123, 1'b1, 16'h0124);
      upd(16'h0123, 1'b1, 16'h0300);
      look(16'h0123, 1'b1, 16'h0300);
      upd(16'h0123, 1'b1, 16'h0300);
      upd(16'h0123, 1'b1, 16'h0300);
      look(16'h0123, 1'b1, 16'h0300);
      upd(16'h0123, 1'b0, 16'h0000);
      look(16'h0123, 1'b1, 16'h0300);
      upd(16'h0123, 1'b0, 16'h0000);
      look(16'h0123, 1'b1, 16'h0124);

      // not-taken misses neither allocate nor evict
      upd(16'h0555, 1'b0, 16'h0999);
      look(16'h0555, 1'b0, 16'h0556);
      upd(16'h1123, 1'b0, 16'h0777);
      look(16'h0123, 1'b1, 16'h0124);
      look(16'h1123, 1'b0, 16'h1124);

      // aliasing eviction on taken update
      upd(16'h0123, 1'b1, 16'h0200);
      look(16'h0123, 1'b1, 16'h0200);
      upd(16'h1123, 1'b1, 16'h0400);
      look(16'h0123, 1'b0, 16'h0124);
      look(16'h1123, 1'b1, 16'h0400);
      look(16'h0124, 1'b0, 16'h0125);

      // reset beats a concurrent update and clears history
      reset_n = 1'b0;
      upd(16'h0010, 1'b1, 16'h0020);
      reset_n = 1'b1;
      look(16'h0010, 1'b0, 16'h0011);
      look(16'h1123, 1'b0, 16'h1124);

      // after reset an allocation starts weakly taken
      upd(16'h0010, 1'b1, 16'h0020);
      look(16'h0010, 1'b1, 16'h0020);
      upd(16'h0010, 1'b0, 16'h0000);
      look(16'h0010, 1'b1, 16'h0011);

      @(negedge clk);
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain: %0d left, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
